// File: rtl/smem_pkg.sv
// Shared types and constants for the shared memory responder (optional parity via SMEM_PARITY_EN).
// No logic here beyond a pure byte-parity helper.
package smem_pkg;

    localparam int ID_W   = 2;
    localparam int WORD_W = 32;
    localparam int BE_W   = WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic [BE_W-1:0]   be;
`ifdef SMEM_PARITY_EN
        logic              par_inject;
`endif
    } req_t;

    // Even parity: the stored bit makes the total count of ones per byte even.
    function automatic logic [BE_W-1:0] byte_parity(input logic [WORD_W-1:0] w);
        logic [BE_W-1:0] p;
        for (int b = 0; b < BE_W; b++) begin
            p[b] = ^w[b*8 +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/smem_array.sv
// Byte-enabled word storage; with SMEM_PARITY_EN also per-byte parity store and read check.
// Write lands on the clock edge when access_en && we; read data and parity error are combinational on idx.
// No flow control: the caller decides when an access happens.
module smem_array
    import smem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic              clk,
    input  logic              access_en,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
`ifdef SMEM_PARITY_EN
    input  logic              par_inject,
    output logic              par_err,
`endif
    output logic [WORD_W-1:0] rdata
);

    // Contents are intentionally not reset.
    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (access_en && we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[idx];

`ifdef SMEM_PARITY_EN
    logic [BE_W-1:0] par_q [DEPTH_WORDS];
    logic [BE_W-1:0] wpar;

    assign wpar = byte_parity(wdata) ^ {BE_W{par_inject}};

    always_ff @(posedge clk) begin
        if (access_en && we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    par_q[idx][b] <= wpar[b];
                end
            end
        end
    end

    // All four bytes are checked on read regardless of be.
    assign par_err = |(byte_parity(mem_q[idx]) ^ par_q[idx]);
`endif

endmodule

// File: rtl/shared_mem_responder.sv
// Single-outstanding shared memory responder, optional per-byte parity under SMEM_PARITY_EN.
// Latency: response valid 1+WAIT_STATES cycles after the request handshake.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module shared_mem_responder
    import smem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ID_W-1:0]   req_id,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
`ifdef SMEM_PARITY_EN
    input  logic              par_inject,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int         AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0] WAIT_LD = 3'(WAIT_STATES);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    req_t              req_q, req_d;
    req_t              in_req, cur_req;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              enter_resp;
    logic              addr_err;
    logic              access_en;
    logic              rd_err;
    logic [WORD_W-1:0] arr_rdata;

    always_comb begin
        in_req            = '0;
        in_req.id         = req_id;
        in_req.we         = req_we;
        in_req.addr       = req_addr;
        in_req.wdata      = req_wdata;
        in_req.be         = req_be;
`ifdef SMEM_PARITY_EN
        in_req.par_inject = par_inject;
`endif
    end

    // With zero wait states the access happens on the accept edge, so the
    // array must see the live request rather than the captured copy.
    assign cur_req  = (state_q == IDLE) ? in_req : req_q;
    assign addr_err = (cur_req.addr[1:0] != 2'b00) ||
                      ({2'b00, cur_req.addr[WORD_W-1:2]} >= 32'(DEPTH_WORDS));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = in_req;
                    cnt_d = WAIT_LD;
                    if (WAIT_LD == 3'd0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    cnt_d      = 3'd0;
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign access_en = enter_resp && !addr_err;

    smem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk        (clk),
        .access_en  (access_en),
        .we         (cur_req.we),
        .idx        (cur_req.addr[AW+1:2]),
        .wdata      (cur_req.wdata),
        .be         (cur_req.be),
`ifdef SMEM_PARITY_EN
        .par_inject (cur_req.par_inject),
        .par_err    (rd_err),
`endif
        .rdata      (arr_rdata)
    );

`ifndef SMEM_PARITY_EN
    assign rd_err = 1'b0;
`endif

    always_comb begin
        rsp_id_d    = rsp_id_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (enter_resp) begin
            rsp_id_d    = cur_req.id;
            rsp_err_d   = addr_err || (!cur_req.we && rd_err);
            rsp_rdata_d = (addr_err || cur_req.we) ? '0 : arr_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            req_q       <= '0;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/shared_mem_responder.md
SHARED_MEM_RESPONDER -- requirements
Module: shared_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored.
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, legal range 0..7: extra access cycles per transaction.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: arbitrated request present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: request accepted this cycle when high together with req_valid.
REQ-007 The block SHALL have port req_id, input, 2 bits: requesting core index.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: write data.
REQ-011 The block SHALL have port req_be, input, 4 bits: byte enables, bit n selects byte n.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: response present.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: core consumes the response.
REQ-014 The block SHALL have port rsp_id, output, 2 bits: echo of the captured req_id.
REQ-015 The block SHALL have port rsp_rdata, output, 32 bits: read data, 0 for writes and errors.
REQ-016 The block SHALL have port rsp_err, output, 1 bit: transaction error flag.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, WAIT and RESP; req_ready SHALL be high only in IDLE.
REQ-018 On the req_valid and req_ready handshake in IDLE, the block SHALL capture id, we, addr, wdata and be, and SHALL go to WAIT if WAIT_STATES>0, else to RESP.
REQ-019 WAIT SHALL count WAIT_STATES cycles using a 3-bit down-counter loaded at accept, and SHALL go to RESP when the counter reaches 0.
REQ-020 The memory access SHALL occur exactly once, on the cycle that enters RESP; for a handshake at cycle N, rsp_valid SHALL first rise at cycle N+1+WAIT_STATES.
REQ-021 A write SHALL update only the bytes enabled by be; be=0000 SHALL complete with no memory change.
REQ-022 A read SHALL return the full word, ignoring be.
REQ-023 An address error is addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; on an address error the block SHALL make no memory access and SHALL set rsp_err=1 and rsp_rdata=0.
REQ-024 In RESP, rsp_valid, rsp_id, rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1; on that handshake the FSM SHALL go to IDLE, so the next accept is no earlier than the following cycle.
REQ-025 req_* inputs SHALL be ignored outside IDLE.
REQ-026 A read that follows a write to the same word SHALL return the written data.

Reset
REQ-027 Asserting reset_n low SHALL immediately force: state IDLE, req_ready=1, rsp_valid=0, rsp_id=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-028 Reset in WAIT or RESP SHALL abort the transaction with no memory write and no response.
REQ-029 Memory contents SHALL NOT be reset; reading a never-written word returns undefined data.

Configuration
REQ-030 Macro SMEM_PARITY_EN defined: the block SHALL store one even-parity bit per byte, computed on write for enabled bytes, and SHALL check all 4 bits on read.
REQ-031 Macro SMEM_PARITY_EN defined: the block SHALL add input par_inject (1 bit), which inverts the stored parity of the enabled bytes on a write.
REQ-032 Macro SMEM_PARITY_EN defined: a read parity mismatch SHALL set rsp_err=1 while still returning the read data.
REQ-033 Macro SMEM_PARITY_EN not defined: no parity storage and no par_inject port SHALL exist, and rsp_err SHALL reflect address errors only.

Structure
REQ-034 Package smem_pkg SHALL hold the state enum, the ID_W=2 and WORD_W=32 constants, and a captured-request struct.
REQ-035 Sub-module smem_array SHALL hold the byte-enabled storage and, under the macro, the parity bits and check logic.

Verification
REQ-036 Write then read, WAIT_STATES=1: write id=2, addr 0x10, data 0xDEADBEEF, be=1111, then read 0x10 -> rsp_rdata=0xDEADBEEF, rsp_id=2, rsp_err=0, rsp_valid 2 cycles after each accept.
REQ-037 Byte enables: write 0x11223344 with be=0101 over a word holding 0x0 -> read returns 0x00220044.
REQ-038 Errors: read addr 0x3 and addr 4*DEPTH_WORDS -> rsp_err=1, rsp_rdata=0; a following read of 0x0 shows no corruption.
REQ-039 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0 throughout; exactly one response completes.
REQ-040 Reset in WAIT: accept a write to 0x20, drop reset_n mid-WAIT -> outputs reach reset values immediately, and a later read of 0x20 shows the old contents.
REQ-041 SMEM_PARITY_EN: write with par_inject=1, then read -> rsp_err=1 with the data intact; a rewrite with par_inject=0 then read -> rsp_err=0.
